jt49_wrarb: RTL and testbench

JT49_WRARB -- requirements
Module: jt49_wrarb

---
 rtl/jt49_pkg.sv | 17 +
 rtl/jt49_fifo.sv | 61 ++++++
 rtl/jt49_wrarb.sv | 126 ++++++++++++
 tb/tb_jt49_wrarb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jt49_pkg.sv
// Shared types for the PSG write arbiter: FSM state encoding and FIFO entry layout.
package jt49_pkg;

    localparam int ENTRY_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] adr;
        logic [7:0] din;
    } entry_t;

endpackage

// File: rtl/jt49_fifo.sv
// Register-based FIFO with power-of-two depth; head is always visible on dout.
module jt49_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign dout    = mem_q[rd_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Pointers are AW bits wide, so wrap-around is free for power-of-two depths.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + 1'b1;
        end
        if (pop_ok) rd_d = rd_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/jt49_wrarb.sv
// Two-requester write arbiter and queue in front of a JT49 PSG register port.
// Define JT49_WRARB_RR_EN for round-robin arbitration; default is fixed priority to A.
module jt49_wrarb
    import jt49_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [3:0] a_adr,
    input  logic [7:0] a_din,
    input  logic       b_valid,
    output logic       b_ready,
    input  logic [3:0] b_adr,
    input  logic [7:0] b_din,
    output logic       psg_cs_n,
    output logic       psg_wr_n,
    output logic [3:0] psg_adr,
    output logic [7:0] psg_din,
    output logic       busy
);
    state_t       state_q, state_d;
    logic         prio_q, prio_d;     // 1: B wins the next contention
    logic         cs_n_q, cs_n_d, wr_n_q, wr_n_d;
    logic [3:0]   adr_q, adr_d;
    logic [7:0]   din_q, din_d;
    logic         full, empty, push, pop;
    logic         a_grant, b_grant;
    entry_t       push_e, head_e;
    logic [ENTRY_W-1:0] head_raw;

    // Ready never looks at adr/din; reset holds both requesters off.
    assign a_ready = ~rst & ~full & ~(b_valid &  prio_q);
    assign b_ready = ~rst & ~full & ~(a_valid & ~prio_q);
    assign a_grant = a_valid & a_ready;
    assign b_grant = b_valid & b_ready;
    assign push    = a_grant | b_grant;
    assign push_e  = a_grant ? entry_t'{adr: a_adr, din: a_din}
                             : entry_t'{adr: b_adr, din: b_din};
    assign head_e  = entry_t'(head_raw);

    jt49_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_e),
        .pop   (pop),
        .dout  (head_raw),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
`ifdef JT49_WRARB_RR_EN
        prio_d = b_grant ? 1'b0 : (a_grant ? 1'b1 : prio_q);
`else
        prio_d = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        cs_n_d  = cs_n_q;
        wr_n_d  = wr_n_q;
        adr_d   = adr_q;
        din_d   = din_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: if (!empty) begin
                pop     = 1'b1;
                adr_d   = head_e.adr;
                din_d   = head_e.din;
                cs_n_d  = 1'b0;
                wr_n_d  = 1'b0;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: if (cen) begin
                cs_n_d  = 1'b1;
                wr_n_d  = 1'b1;
                state_d = ST_GAP;
            end
            // One full PSG cycle with strobes high separates consecutive writes.
            ST_GAP: if (cen) begin
                if (!empty) begin
                    pop     = 1'b1;
                    adr_d   = head_e.adr;
                    din_d   = head_e.din;
                    cs_n_d  = 1'b0;
                    wr_n_d  = 1'b0;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            adr_q   <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cs_n_q  <= cs_n_d;
            wr_n_q  <= wr_n_d;
            adr_q   <= adr_d;
            din_q   <= din_d;
        end
    end

    assign psg_cs_n = cs_n_q;
    assign psg_wr_n = wr_n_q;
    assign psg_adr  = adr_q;
    assign psg_din  = din_q;
    assign busy     = ~empty | (state_q != ST_IDLE);

endmodule

// File: tb/tb_jt49_wrarb.sv
// Directed bench for jt49_wrarb: reset, single write, contention, full, stall, reset abort, wrap.
module tb_jt49_wrarb;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic       a_ready, b_ready;
    logic [3:0] a_adr = '0, b_adr = '0;
    logic [7:0] a_din = '0, b_din = '0;
    logic       psg_cs_n, psg_wr_n, busy;
    logic [3:0] psg_adr;
    logic [7:0] psg_din;

    int checks = 0;
    int errors = 0;
    int cen_per = 0;
    int cen_cnt = 0;

    logic [11:0] aq[$], bq[$], acc_q[$], psg_q[$];

    jt49_wrarb #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .a_valid(a_valid), .a_ready(a_ready), .a_adr(a_adr), .a_din(a_din),
        .b_valid(b_valid), .b_ready(b_ready), .b_adr(b_adr), .b_din(b_din),
        .psg_cs_n(psg_cs_n), .psg_wr_n(psg_wr_n), .psg_adr(psg_adr),
        .psg_din(psg_din), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (cen_per == 0) begin
            cen = 1'b0;
            cen_cnt = 0;
        end else begin
            cen_cnt = (cen_cnt + 1 >= cen_per) ? 0 : cen_cnt + 1;
            cen = (cen_cnt == 0);
        end
    end

    // Inputs change just after posedge, so the negedge sees what the next edge will act on.
    always @(negedge clk) begin
        if (a_valid && a_ready)      acc_q.push_back({a_adr, a_din});
        else if (b_valid && b_ready) acc_q.push_back({b_adr, b_din});
        if (!rst && cen && !psg_cs_n && !psg_wr_n) psg_q.push_back({psg_adr, psg_din});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tb_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        acc_q.delete();
        psg_q.delete();
    endtask

    task automatic run_reqs(input bit rnd, input int budget);
        int  n = 0;
        bit  ga, gb;
        while ((aq.size() > 0 || bq.size() > 0) && n < budget) begin
            a_valid = (aq.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
            b_valid = (bq.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
            if (aq.size() > 0) {a_adr, a_din} = aq[0];
            if (bq.size() > 0) {b_adr, b_din} = bq[0];
            @(negedge clk);
            ga = a_valid && a_ready;
            gb = b_valid && b_ready;
            @(posedge clk); #1;
            if (ga) void'(aq.pop_front());
            if (gb) void'(bq.pop_front());
            n++;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk("drv_done", aq.size() + bq.size(), 0);
    endtask

    task automatic wait_psg(input string tag, input int want, input int budget);
        int n = 0;
        while (psg_q.size() < want && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, psg_q.size(), want);
    endtask

    logic [11:0] exp_c [4];
    logic [23:0] snap;
    int n, gap, bad;

    initial begin
        // Reset state, with both requesters asserting valid
        a_valid = 1'b1;
        b_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cs", psg_cs_n, 1);
        chk("rst_wr", psg_wr_n, 1);
        chk("rst_adr", psg_adr, 0);
        chk("rst_din", psg_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ardy", a_ready, 0);
        chk("rst_brdy", b_ready, 0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst = 1'b0;

        // Single write
        cen_per = 4;
        aq.push_back({4'd7, 8'h38});
        run_reqs(0, 20);
        n = 0;
        while (psg_cs_n && n < 20) begin @(negedge clk); n++; end
        chk("sw_cs", psg_cs_n, 0);
        chk("sw_wr", psg_wr_n, 0);
        chk("sw_adr", psg_adr, 7);
        chk("sw_din", psg_din, 8'h38);
        n = 0;
        while (!psg_cs_n && n < 20) begin @(negedge clk); n++; end
        chk("sw_issue_end", psg_cs_n, 1);
        gap = 0; bad = 0; n = 0;
        while (busy && n < 20) begin
            if (!psg_cs_n || !psg_wr_n) bad++;
            gap++;
            @(negedge clk);
            n++;
        end
        chk("sw_gap_len", gap, 4);
        chk("sw_gap_hi", bad, 0);
        chk("sw_keep_adr", psg_adr, 7);
        chk("sw_keep_din", psg_din, 8'h38);
        chk("sw_cnt", psg_q.size(), 1);
        chk("sw_log", psg_q[0], 12'h738);

        // Contention
        tb_reset();
        cen_per = 4;
        aq.push_back(12'h011); aq.push_back(12'h133);
        bq.push_back(12'h222); bq.push_back(12'h344);
`ifdef JT49_WRARB_RR_EN
        exp_c[0] = 12'h011; exp_c[1] = 12'h222; exp_c[2] = 12'h133; exp_c[3] = 12'h344;
`else
        exp_c[0] = 12'h011; exp_c[1] = 12'h133; exp_c[2] = 12'h222; exp_c[3] = 12'h344;
`endif
        run_reqs(0, 40);
        wait_psg("ct_cnt", 4, 200);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ct_acc%0d", i), (acc_q.size() > i) ? acc_q[i] : 12'hfff, exp_c[i]);
            chk($sformatf("ct_psg%0d", i), (psg_q.size() > i) ? psg_q[i] : 12'hfff, exp_c[i]);
        end

        // Full: one entry parks in ISSUE, DEPTH more fill the queue, the next is refused
        tb_reset();
        cen_per = 0;
        for (int i = 0; i < 5; i++) aq.push_back({4'(i), 8'hA0 + 8'(i)});
        run_reqs(0, 10);
        a_valid = 1'b1;
        a_adr = 4'd5;
        a_din = 8'hA5;
        @(negedge clk);
        chk("full_ardy", a_ready, 0);
        chk("full_brdy", b_ready, 0);
        chk("full_busy", busy, 1);
        chk("full_nowr", psg_q.size(), 0);
        aq.push_back({4'd5, 8'hA5});
        cen_per = 4;
        run_reqs(0, 80);
        wait_psg("full_cnt", 6, 300);
        for (int i = 0; i < 6; i++)
            chk($sformatf("full_psg%0d", i), (psg_q.size() > i) ? psg_q[i] : 12'hfff,
                {4'(i), 8'hA0 + 8'(i)});

        // Stall with cen held low during ISSUE
        tb_reset();
        cen_per = 0;
        aq.push_back(12'h95A);
        run_reqs(0, 10);
        n = 0;
        while (psg_cs_n && n < 20) begin @(negedge clk); n++; end
        chk("stall_cs", psg_cs_n, 0);
        snap = {psg_cs_n, psg_wr_n, 2'b00, psg_adr, psg_din, 8'h00};
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({psg_cs_n, psg_wr_n, 2'b00, psg_adr, psg_din, 8'h00} !== snap || !busy) bad++;
        end
        chk("stall_stable", bad, 0);
        cen_per = 4;
        wait_psg("stall_cnt", 1, 50);
        chk("stall_log", psg_q[0], 12'h95A);

        // Reset while a write is in ISSUE and three more are queued
        tb_reset();
        cen_per = 0;
        for (int i = 0; i < 4; i++) aq.push_back({4'(i + 8), 8'h50 + 8'(i)});
        run_reqs(0, 10);
        repeat (2) @(negedge clk);
        chk("ra_pre_cs", psg_cs_n, 0);
        #2 rst = 1'b1;
        #1;
        chk("ra_cs", psg_cs_n, 1);
        chk("ra_wr", psg_wr_n, 1);
        chk("ra_adr", psg_adr, 0);
        chk("ra_din", psg_din, 0);
        chk("ra_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cen_per = 2;
        repeat (40) @(negedge clk);
        chk("ra_nowr", psg_q.size(), 0);
        chk("ra_idle", busy, 0);

        // Wrap: random traffic with pushes and pops overlapping
        tb_reset();
        cen_per = 2;
        for (int i = 0; i < 10; i++) begin
            aq.push_back(12'($urandom));
            bq.push_back(12'($urandom));
        end
        run_reqs(1, 400);
        wait_psg("wr_cnt", 20, 600);
        chk("wr_acc_cnt", acc_q.size(), 20);
        bad = 0;
        for (int i = 0; i < 20; i++)
            if (acc_q.size() <= i || psg_q.size() <= i || acc_q[i] !== psg_q[i]) bad++;
        chk("wr_order", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
